camellia_ka_gen: RTL
====================

# camellia_ka_gen

Iterative generator of the Camellia-128 intermediate key KA from the 128-bit user key KL. It sits upstream of the subkey expander: it consumes KL, runs the four-round Feistel key-mixing network one F-function per cycle, and presents KL/KA-ready key material with a start/done handshake. The subkey expander is started only after this block's `KA_VALID` rises.

## Interface
Parameters:
- none; all constants are fixed by the Camellia-128 key schedule.

Ports:
- `CLK`  in  1  sole clock, rising edge.
- `RST`  in  1  reset, synchronous, active-high.
- `START`  in  1  request a KA computation; sampled only in IDLE.
- `KL`  in  128  user key; captured on the accepted `START` edge.
- `BUSY`  out  1  high while a computation is in progress.
- `DONE`  out  1  one-cycle pulse when `KA` is updated.
- `KA`  out  128  generated KA; holds until the next completion or reset.
- `KA_VALID`  out  1  level; `KA` corresponds to the last accepted `KL`.

## Operation
- Registers: `D1`, `D2` (64 b each), `KLQ` (128 b captured key), round counter `RND` (2 b), output `KA`.
- Sigma constants:
  - SIGMA1 = A09E667F3BCC908B
  - SIGMA2 = B67AE8584CAA73B2
  - SIGMA3 = C6EF372FE94F82BE
  - SIGMA4 = 54FF53A5F1D36F1C
- On accept:
  - `KLQ` ← `KL`
  - `D1` ← `KL[127:64]`
  - `D2` ← `KL[63:0]`
  - `RND` ← 0
- Round 0: `D2` ^= F(`D1`, SIGMA1).
- Round 1: `D1` ← `D1` ^ F(`D2`, SIGMA2) ^ `KLQ[127:64]` and `D2` ← `D2` ^ `KLQ[63:0]`, both in the same cycle (fused KL re-mix).
- Round 2: `D2` ^= F(`D1`, SIGMA3).
- Round 3: `D1` ^= F(`D2`, SIGMA4), and `KA` ← {new `D1`, `D2`}.
- F(X,k): y = X^k, split into 8 bytes, pass through S-boxes s1,s2,s3,s4,s2,s3,s4,s1 (MSB byte first), then apply the Camellia P-function. All XOR and rotate operations are 64-bit with no carries.
- FSM:
  - IDLE: `START` → RUN.
  - RUN: `RND` increments each cycle; after round 3 → IDLE.
  - There is no separate DONE state; `DONE` is asserted on the cycle following the round-3 edge.
- `START` while `BUSY` is ignored with no queueing. Changes on `KL` during RUN have no effect.
- `KA_VALID` clears on an accepted `START` and sets together with `DONE`.

## Timing
- Reset values: `BUSY`=0, `DONE`=0, `KA`=0, `KA_VALID`=0, FSM=IDLE, `D1`/`D2`/`KLQ`/`RND`=0.
- `START` accepted at edge t → `BUSY`=1 from t to t+4.
- Rounds 0–3 execute at edges t+1..t+4.
- `KA`, `KA_VALID`=1 and `DONE`=1 are visible after edge t+4. `BUSY`=0 in the same cycle.
- Latency is 4 cycles from accepting edge to `KA`. The shortest start-to-start interval is 5 cycles: a new `START` may be accepted in the `DONE` cycle.
- Reset mid-RUN aborts immediately and all outputs return to their reset values. `RST` has priority over `START` on the same edge.
- `START` held high continuously restarts a computation in every IDLE cycle.

## Configuration
- `CAMELLIA_KA_CACHE_EN` defined:
  - An accepted `START` whose `KL` equals `KLQ` while `KA_VALID`=1 skips the rounds.
  - `DONE` pulses on the next cycle, `KA` and `KA_VALID` are unchanged, and `BUSY` stays 0.
- Undefined: every `START` runs the full 4 rounds; no comparator is built.

## Structure
- `camellia_pkg` holds:
  - SIGMA1..SIGMA4 as 64-bit localparams.
  - The FSM state enum typedef (IDLE, RUN).
  - The S-box function (single SBOX1 table; s2 = rotl1(s1(x)), s3 = rotl7(s1(x)), s4 = s1(rotl1(x))).
  - The P-function.
- One sub-module, `camellia_f`: combinational F(X,k), 64-bit data and key inputs, 64-bit output. It is the same unit used by the round datapath. This block instantiates a single `camellia_f` and muxes its operands by `RND`.

## Test plan
- **RFC 3713 key:** reset, then `KL`=0123456789ABCDEFFEDCBA9876543210 with `START` for 1 cycle → `DONE` exactly 4 cycles after the accepting edge, and `KA` matches the golden model. Feeding it with `KL` to the expander and datapath, plaintext 0123456789ABCDEFFEDCBA9876543210 encrypts to 67673138549669730857065648EABE43.
- **Zero key:** `KL`=0 → `KA` equals the golden model for key 0; `KA_VALID` rises with `DONE`; `BUSY` is high for exactly 4 cycles.
- **Start while busy:** a second `START` with a different `KL` on cycle t+2 → ignored; `KA` reflects the first key; only one `DONE` pulse.
- **Reset mid-operation:** `RST` at t+2 → next cycle `BUSY`=0, `KA`=0, `KA_VALID`=0, and no `DONE`. A following `START` completes normally.
- **Back-to-back:** `START` in the `DONE` cycle with a new key → accepted; second `DONE` 5 cycles after the first; `KA_VALID` is low between the two.
- **Cache hit** (`CAMELLIA_KA_CACHE_EN` only): repeat the same `KL` → `DONE` after 1 cycle, `BUSY` stays 0, `KA` unchanged. A different `KL` → full 4-cycle run.

Source files
------------

// File: rtl/camellia_pkg.sv
// Camellia-128 key-schedule constants, FSM state type, S-box and P-function helpers.
// Pure declarations, no state; shared by the F-function and the KA generator.
package camellia_pkg;

    localparam logic [63:0] SIGMA1 = 64'hA09E667F3BCC908B;
    localparam logic [63:0] SIGMA2 = 64'hB67AE8584CAA73B2;
    localparam logic [63:0] SIGMA3 = 64'hC6EF372FE94F82BE;
    localparam logic [63:0] SIGMA4 = 64'h54FF53A5F1D36F1C;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } ka_state_t;

    // SBOX1 with entry 0 in the most significant byte.
    localparam logic [2047:0] SBOX1_TBL = {
        128'h70822cecb327c0e5e4855735ea0cae41,
        128'h23ef6b934519a521ed0e4f4e1d6592bd,
        128'h86b8af8f7ceb1fce3e30dc5f5ec50b1a,
        128'ha6e139cad5475d3dd9015ad651566c4d,
        128'h8b0d9a66fbccb02d74122b20f0b18499,
        128'hdf4ccbc2347e76056db7a931d11704d7,
        128'h14583a61de1b111c320f9c165318f222,
        128'hfe44cfb2c3b57a912408e8a860fc6950,
        128'haad0a07da1896297545b1e95e0ff64d2,
        128'h10c40048a3f775db8a03e6da093fdd94,
        128'h875c8302cd4a90337367f6f39d7fbfe2,
        128'h529bd826c837c63b81966f4b13be632e,
        128'he979a78c9f6ebc8e29f5f9b62ffdb459,
        128'h7898066ae74671bad425ab4288a28dfa,
        128'h7207b955f8eeac0a36492a683c38f1a4,
        128'h4028d37bbbc943c115e3adf477c7809e
    };

    function automatic logic [7:0] sbox1(input logic [7:0] x);
        logic [10:0] msb;
        msb = 11'd2047 - {x, 3'b000};
        return SBOX1_TBL[msb -: 8];
    endfunction

    function automatic logic [7:0] sbox2(input logic [7:0] x);
        logic [7:0] s;
        s = sbox1(x);
        return {s[6:0], s[7]};
    endfunction

    function automatic logic [7:0] sbox3(input logic [7:0] x);
        logic [7:0] s;
        s = sbox1(x);
        return {s[0], s[7:1]};
    endfunction

    function automatic logic [7:0] sbox4(input logic [7:0] x);
        return sbox1({x[6:0], x[7]});
    endfunction

    function automatic logic [63:0] p_fn(input logic [63:0] z);
        logic [7:0] z1, z2, z3, z4, z5, z6, z7, z8;
        {z1, z2, z3, z4, z5, z6, z7, z8} = z;
        return {z1 ^ z3 ^ z4 ^ z6 ^ z7 ^ z8,
                z1 ^ z2 ^ z4 ^ z5 ^ z7 ^ z8,
                z1 ^ z2 ^ z3 ^ z5 ^ z6 ^ z8,
                z2 ^ z3 ^ z4 ^ z5 ^ z6 ^ z7,
                z1 ^ z2 ^ z6 ^ z7 ^ z8,
                z2 ^ z3 ^ z5 ^ z7 ^ z8,
                z3 ^ z4 ^ z5 ^ z6 ^ z8,
                z1 ^ z4 ^ z5 ^ z6 ^ z7};
    endfunction

endpackage

// File: rtl/camellia_f.sv
// Camellia F-function: key XOR, S-box layer, P-function.
// Purely combinational, zero latency; no flow control.
module camellia_f
    import camellia_pkg::*;
(
    input  logic [63:0] x_dat,
    input  logic [63:0] k_dat,
    output logic [63:0] f_dat
);

    logic [63:0] y;
    logic [63:0] s;

    always_comb begin
        y = x_dat ^ k_dat;
        s = {sbox1(y[63:56]), sbox2(y[55:48]), sbox3(y[47:40]), sbox4(y[39:32]),
             sbox2(y[31:24]), sbox3(y[23:16]), sbox4(y[15:8]),  sbox1(y[7:0])};
    end

    assign f_dat = p_fn(s);

endmodule

// File: rtl/camellia_ka_gen.sv
// Iterative Camellia-128 KA generator, one F-function per cycle (optional CAMELLIA_KA_CACHE_EN).
// Latency 4 cycles from accepted START to KA/DONE; START while BUSY is dropped, not queued.
module camellia_ka_gen
    import camellia_pkg::*;
(
    input  logic         CLK,
    input  logic         RST,
    input  logic         START,
    input  logic [127:0] KL,
    output logic         BUSY,
    output logic         DONE,
    output logic [127:0] KA,
    output logic         KA_VALID
);

    ka_state_t    state_q, state_d;
    logic [63:0]  d1_q, d1_d;
    logic [63:0]  d2_q, d2_d;
    logic [127:0] klq_q, klq_d;
    logic [127:0] ka_q, ka_d;
    logic [1:0]   rnd_q, rnd_d;
    logic         done_q, done_d;
    logic         ka_vld_q, ka_vld_d;
    logic [63:0]  f_x_dat, f_k_dat, f_dat;
    logic         cache_hit;

`ifdef CAMELLIA_KA_CACHE_EN
    assign cache_hit = ka_vld_q && (KL == klq_q);
`else
    assign cache_hit = 1'b0;
`endif

    // Even rounds feed D1 into F, odd rounds feed D2.
    always_comb begin
        f_x_dat = rnd_q[0] ? d2_q : d1_q;
        case (rnd_q)
            2'd0:    f_k_dat = SIGMA1;
            2'd1:    f_k_dat = SIGMA2;
            2'd2:    f_k_dat = SIGMA3;
            default: f_k_dat = SIGMA4;
        endcase
    end

    camellia_f u_f (
        .x_dat (f_x_dat),
        .k_dat (f_k_dat),
        .f_dat (f_dat)
    );

    always_comb begin
        state_d  = state_q;
        d1_d     = d1_q;
        d2_d     = d2_q;
        klq_d    = klq_q;
        ka_d     = ka_q;
        rnd_d    = rnd_q;
        done_d   = 1'b0;
        ka_vld_d = ka_vld_q;
        case (state_q)
            IDLE: begin
                if (START) begin
                    if (cache_hit) begin
                        done_d = 1'b1;
                    end else begin
                        klq_d    = KL;
                        d1_d     = KL[127:64];
                        d2_d     = KL[63:0];
                        rnd_d    = 2'd0;
                        ka_vld_d = 1'b0;
                        state_d  = RUN;
                    end
                end
            end
            RUN: begin
                rnd_d = rnd_q + 2'd1;
                case (rnd_q)
                    2'd0: d2_d = d2_q ^ f_dat;
                    2'd1: begin
                        // KL re-mix folded into the second round.
                        d1_d = d1_q ^ f_dat ^ klq_q[127:64];
                        d2_d = d2_q ^ klq_q[63:0];
                    end
                    2'd2: d2_d = d2_q ^ f_dat;
                    default: begin
                        d1_d     = d1_q ^ f_dat;
                        ka_d     = {d1_q ^ f_dat, d2_q};
                        ka_vld_d = 1'b1;
                        done_d   = 1'b1;
                        state_d  = IDLE;
                    end
                endcase
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= IDLE;
            d1_q     <= '0;
            d2_q     <= '0;
            klq_q    <= '0;
            ka_q     <= '0;
            rnd_q    <= '0;
            done_q   <= 1'b0;
            ka_vld_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            d1_q     <= d1_d;
            d2_q     <= d2_d;
            klq_q    <= klq_d;
            ka_q     <= ka_d;
            rnd_q    <= rnd_d;
            done_q   <= done_d;
            ka_vld_q <= ka_vld_d;
        end
    end

    assign BUSY     = (state_q == RUN);
    assign DONE     = done_q;
    assign KA       = ka_q;
    assign KA_VALID = ka_vld_q;

endmodule
